// File: rtl/spu_issue_stage_if.sv
// Fetch-to-issue bus of the dual-issue stage: fetch handshake, flush request
// and the two routed pipe outputs.
interface spu_issue_stage_if #(
  parameter int PC_W = 8
);
  logic            fetch_valid;
  logic            fetch_ready;
  logic [31:0]     instr_a;
  logic [31:0]     instr_b;
  logic [PC_W-1:0] pc_in;
  logic            branch_taken;
  logic [31:0]     instr_even;
  logic [31:0]     instr_odd;
  logic [PC_W-1:0] pc_out;

  modport master (
    output fetch_valid, instr_a, instr_b, pc_in, branch_taken,
    input  fetch_ready, instr_even, instr_odd, pc_out
  );

  modport slave (
    input  fetch_valid, instr_a, instr_b, pc_in, branch_taken,
    output fetch_ready, instr_even, instr_odd, pc_out
  );
endinterface

// File: rtl/spu_issue_stage.sv
// Dual-issue stage: routes a program-ordered pair to the even/odd pipes in one
// cycle, or splits it over two cycles when the pair cannot issue together.
module spu_issue_stage #(
  parameter int PC_W = 8
) (
  input logic               clk,
  input logic               reset,
  spu_issue_stage_if.slave  bus
);

  typedef enum logic {ACCEPT = 1'b0, SECOND = 1'b1} state_t;

  state_t          state_reg, state_next;
  logic [31:0]     hold_instr_reg, hold_instr_next;
  logic [PC_W-1:0] hold_pc_reg, hold_pc_next;
  logic [31:0]     even_reg, even_next;
  logic [31:0]     odd_reg, odd_next;
  logic [PC_W-1:0] pc_out_reg, pc_out_next;

  logic            a_nop, b_nop, a_odd, b_odd, held_odd;
  logic            dependent, dual;
  logic [6:0]      rt_a;
  logic [1:0]      src_hit;
  logic [PC_W-1:0] pc_b;

  // Bit 0 of an instruction is its MSB, so instr[0:2] lives in [31:29].
  assign a_nop    = (bus.instr_a == 32'h0);
  assign b_nop    = (bus.instr_b == 32'h0);
  assign a_odd    = (bus.instr_a[31:29] == 3'b001);
  assign b_odd    = (bus.instr_b[31:29] == 3'b001);
  assign held_odd = (hold_instr_reg[31:29] == 3'b001);
  assign rt_a     = bus.instr_a[6:0];
  assign pc_b     = bus.pc_in + PC_W'(1);

  // Source fields of b: instr[18:24] -> [13:7], instr[11:17] -> [20:14].
  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    assign src_hit[gi] = (bus.instr_b[13 + 7*gi -: 7] == rt_a);
  end

  assign dependent = (|src_hit) && !a_nop && !b_nop;
  assign dual      = a_nop || b_nop || ((a_odd != b_odd) && !dependent);

  always_comb begin
    state_next      = state_reg;
    hold_instr_next = hold_instr_reg;
    hold_pc_next    = hold_pc_reg;
    even_next       = 32'h0;
    odd_next        = 32'h0;
    pc_out_next     = pc_out_reg;
    if (bus.branch_taken) begin
      state_next      = ACCEPT;
      hold_instr_next = 32'h0;
      hold_pc_next    = '0;
    end else begin
      case (state_reg)
        ACCEPT: begin
          if (bus.fetch_valid) begin
            if (!a_nop) begin
              if (a_odd) odd_next = bus.instr_a;
              else       even_next = bus.instr_a;
            end
            if (dual) begin
              // A dual pair never collides: b is a nop or of the other class.
              if (!b_nop) begin
                if (b_odd) odd_next = bus.instr_b;
                else       even_next = bus.instr_b;
              end
              pc_out_next = a_nop ? pc_b : bus.pc_in;
            end else begin
              pc_out_next     = bus.pc_in;
              hold_instr_next = bus.instr_b;
              hold_pc_next    = pc_b;
              state_next      = SECOND;
            end
          end
        end
        SECOND: begin
          if (held_odd) odd_next = hold_instr_reg;
          else          even_next = hold_instr_reg;
          pc_out_next     = hold_pc_reg;
          hold_instr_next = 32'h0;
          hold_pc_next    = '0;
          state_next      = ACCEPT;
        end
        default: state_next = ACCEPT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ACCEPT;
      hold_instr_reg <= 32'h0;
      hold_pc_reg    <= '0;
      even_reg       <= 32'h0;
      odd_reg        <= 32'h0;
      pc_out_reg     <= '0;
    end else begin
      state_reg      <= state_next;
      hold_instr_reg <= hold_instr_next;
      hold_pc_reg    <= hold_pc_next;
      even_reg       <= even_next;
      odd_reg        <= odd_next;
      pc_out_reg     <= pc_out_next;
    end
  end

  assign bus.fetch_ready = (state_reg == ACCEPT);
  assign bus.instr_even  = even_reg;
  assign bus.instr_odd   = odd_reg;
  assign bus.pc_out      = pc_out_reg;

endmodule

// File: tb/tb_spu_issue_stage.sv
// Scoreboard bench for spu_issue_stage: a pair-level reference model queues
// expected issues; a separate monitor pops them as the pipes see instructions.
module tb_spu_issue_stage;
  localparam int PC_W = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  spu_issue_stage_if #(.PC_W(PC_W)) bus ();
  spu_issue_stage #(.PC_W(PC_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [31:0]     even;
    logic [31:0]     odd;
    logic [PC_W-1:0] pc;
    int              cyc;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc_cnt = 0;

  // Instructions still owed to the pipes from an already accepted pair.
  bit              pend_valid = 1'b0;
  logic [31:0]     pend_b;
  logic [PC_W-1:0] pend_pc;
  bit              last_acc = 1'b0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  function automatic bit is_odd(input logic [31:0] x);
    return (x >> 29) == 32'd1;
  endfunction

  function automatic bit dep(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] rt;
    rt = a & 32'h7F;
    return (a != 0) && (b != 0) &&
           ((((b >> 7) & 32'h7F) == rt) || (((b >> 14) & 32'h7F) == rt));
  endfunction

  function automatic exp_t place(input logic [31:0] x, input exp_t e);
    exp_t r;
    r = e;
    if (x != 0) begin
      if (is_odd(x)) r.odd = x;
      else           r.even = x;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic push(input exp_t e);
    if (e.even != 0 || e.odd != 0) sb.push_back(e);
  endtask

  // One clock cycle: drive inputs at the falling edge, check readiness and
  // predict what the next rising edge must issue.
  task automatic step(input bit rst, input bit v, input logic [31:0] a,
                      input logic [31:0] b, input logic [PC_W-1:0] pc, input bit br);
    exp_t e;
    @(negedge clk);
    reset            = rst;
    bus.fetch_valid  = v;
    bus.instr_a      = a;
    bus.instr_b      = b;
    bus.pc_in        = pc;
    bus.branch_taken = br;
    #1;
    check("fetch_ready", {31'h0, bus.fetch_ready}, {31'h0, !pend_valid});
    e.even = 32'h0;
    e.odd  = 32'h0;
    e.pc   = '0;
    e.cyc  = cyc_cnt + 1;
    last_acc = 1'b0;
    if (rst || br) begin
      pend_valid = 1'b0;
    end else if (pend_valid) begin
      e = place(pend_b, e);
      e.pc = pend_pc;
      push(e);
      pend_valid = 1'b0;
    end else if (v) begin
      last_acc = 1'b1;
      e = place(a, e);
      if (a == 0 || b == 0 || (is_odd(a) != is_odd(b) && !dep(a, b))) begin
        e = place(b, e);
        e.pc = (a == 0) ? pc + 1 : pc;
      end else begin
        e.pc = pc;
        pend_valid = 1'b1;
        pend_b     = b;
        pend_pc    = pc + 1;
      end
      push(e);
    end
  endtask

  function automatic logic [31:0] gen_instr();
    logic [31:0] x;
    int unsigned r;
    r = $urandom_range(0, 7);
    if (r == 0) return 32'h0;
    x = $urandom;
    if (r < 4) x[31:29] = 3'b001;
    else if (x[31:29] == 3'b001) x[31:29] = 3'b011;
    return x;
  endfunction

  // Monitor: every cycle the pipes see an instruction, pop and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      while (sb.size() > 0 && sb[0].cyc < cyc_cnt) begin
        e = sb.pop_front();
        n_cmp++;
        n_bad++;
        $display("FAIL missing_issue: got nothing by cycle %0d, expected even=%h odd=%h pc=%h at cycle %0d",
                 cyc_cnt, e.even, e.odd, e.pc, e.cyc);
      end
      if (bus.instr_even !== 32'h0 || bus.instr_odd !== 32'h0) begin
        if (sb.size() == 0 || sb[0].cyc != cyc_cnt) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_issue: got even=%h odd=%h pc=%h at cycle %0d, expected no issue",
                   bus.instr_even, bus.instr_odd, bus.pc_out, cyc_cnt);
        end else begin
          e = sb.pop_front();
          $display("issue cyc=%0d even=%h odd=%h pc=%h", cyc_cnt, bus.instr_even, bus.instr_odd, bus.pc_out);
          check("instr_even", bus.instr_even, e.even);
          check("instr_odd", bus.instr_odd, e.odd);
          check("pc_out", {24'h0, bus.pc_out}, {24'h0, e.pc});
        end
      end
    end
  end

  initial begin
    bit              cur_v;
    logic [31:0]     cur_a, cur_b;
    logic [PC_W-1:0] cur_pc;

    bus.fetch_valid  = 1'b1;
    bus.instr_a      = 32'h58808083;
    bus.instr_b      = 32'h3B614206;
    bus.pc_in        = 8'h10;
    bus.branch_taken = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_even", bus.instr_even, 32'h0);
    check("reset_odd", bus.instr_odd, 32'h0);
    check("reset_pc", {24'h0, bus.pc_out}, 32'h0);
    check("reset_ready", {31'h0, bus.fetch_ready}, 32'h1);

    // Directed: dual (both orders), same-class split, dependency split,
    // flush during the second half of a split, nop with PC wrap.
    step(0, 1, 32'h58808083, 32'h3B614206, 8'h10, 0);
    step(0, 1, 32'h3B614206, 32'h58808083, 8'h12, 0);
    step(0, 1, 32'h58808083, 32'h58808103, 8'h20, 0);
    step(0, 1, 32'h58808083, 32'h58808103, 8'h20, 0);
    step(0, 1, 32'h58808083, 32'h20000180, 8'h24, 0);
    step(0, 1, 32'h58808083, 32'h20000180, 8'h24, 0);
    step(0, 1, 32'h58808083, 32'h58808103, 8'h30, 0);
    step(0, 1, 32'h58808083, 32'h58808103, 8'h30, 1);
    step(0, 1, 32'h3B614206, 32'h58808083, 8'h40, 0);
    step(0, 1, 32'h00000000, 32'h58808083, 8'hFF, 0);
    step(0, 0, 32'h0, 32'h0, 8'h0, 0);
    // Reset while a split is in its second half discards the held b.
    step(0, 1, 32'h58808083, 32'h58808103, 8'h50, 0);
    step(1, 0, 32'h0, 32'h0, 8'h0, 0);
    step(0, 0, 32'h0, 32'h0, 8'h0, 0);

    cur_v = 1'b0;
    cur_a = 32'h0;
    cur_b = 32'h0;
    cur_pc = '0;
    for (int i = 0; i < 3000; i++) begin
      // A pair offered but not taken is held stable until accepted.
      if (!cur_v || last_acc) begin
        cur_v  = ($urandom_range(0, 3) != 0);
        cur_a  = gen_instr();
        cur_b  = gen_instr();
        cur_pc = PC_W'($urandom);
        if (cur_a != 0 && cur_b != 0 && $urandom_range(0, 2) == 0) begin
          if ($urandom_range(0, 1) == 0) cur_b[13:7] = cur_a[6:0];
          else                           cur_b[20:14] = cur_a[6:0];
        end
      end
      step($urandom_range(0, 299) == 0, cur_v, cur_a, cur_b, cur_pc,
           $urandom_range(0, 9) == 0);
    end

    repeat (4) step(0, 0, 32'h0, 32'h0, 8'h0, 0);
    @(negedge clk);
    check("scoreboard_drained", sb.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
